// File: rtl/hamming14_4_pkg.sv
// Shared definitions for the (14,4) SEC code. The syndrome decoder reuses
// calc_parity, so the encoder and decoder cannot drift apart.
package hamming14_4_pkg;

    localparam int DATA_W = 4;
    localparam int PAR_W  = 10;
    localparam int CW_W   = 14;

    typedef logic [CW_W-1:0] cw_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_e;

    function automatic logic [PAR_W-1:0] calc_parity(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        p[0] = d[0];
        p[1] = d[0] ^ d[1];
        p[2] = d[0] ^ d[2];
        p[3] = d[1] ^ d[2];
        p[4] = d[0] ^ d[1] ^ d[2];
        p[5] = d[0] ^ d[3];
        p[6] = d[1] ^ d[3];
        p[7] = d[0] ^ d[1] ^ d[3];
        p[8] = d[2] ^ d[3];
        p[9] = d[0] ^ d[2] ^ d[3];
        return p;
    endfunction

endpackage

// File: rtl/hamming_cw_fifo.sv
// Synchronous codeword FIFO with valid/ready on both sides. Ready and valid
// come only from the occupancy counter, so there is no path from pop to push.
module hamming_cw_fifo
    import hamming14_4_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push_valid,
    output logic o_push_ready,
    input  cw_t  i_push_data,
    output logic o_pop_valid,
    input  logic i_pop_ready,
    output cw_t  o_pop_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    cw_t              r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    occ_state_e       w_state;
    logic             w_push;
    logic             w_pop;

    // NOTE: every always_comb output gets a default first, so no latch can form.
    always_comb begin
        w_state = OCC_PARTIAL;
        if (r_occ == '0) begin
            w_state = OCC_EMPTY;
        end else if (r_occ == DEPTH_C) begin
            w_state = OCC_FULL;
        end
    end

    assign o_push_ready = (w_state != OCC_FULL);
    assign o_pop_valid  = (w_state != OCC_EMPTY);
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;

    // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy decides validity and the head is
    // masked to zero while empty, so stale entries are never observable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_pop_data = (w_state == OCC_EMPTY) ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/hamming14_4_encoder.sv
// Streaming (14,4) systematic encoder: cx = {d, parity}, buffered in a small FIFO.
// Optional macro HAMMING_ERR_INJ_EN adds single-bit error injection ports.
module hamming14_4_encoder
    import hamming14_4_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_cx,
    output logic [CNT_W-1:0]  cw_count
`ifdef HAMMING_ERR_INJ_EN
    ,
    input  logic              inj_en,
    input  logic [3:0]        inj_pos
`endif
);

    cw_t              w_clean_cx;
    cw_t              w_cx;
    logic [CNT_W-1:0] r_cw_count;

    assign w_clean_cx = {in_data, calc_parity(in_data)};

`ifdef HAMMING_ERR_INJ_EN
    cw_t w_flip_mask;

    // Positions 14 and 15 are deliberately "no flip".
    always_comb begin
        w_flip_mask = '0;
        if (inj_en && (inj_pos <= 4'd13)) begin
            w_flip_mask[inj_pos] = 1'b1;
        end
    end

    assign w_cx = w_clean_cx ^ w_flip_mask;
`else
    assign w_cx = w_clean_cx;
`endif

    hamming_cw_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (in_valid),
        .o_push_ready (in_ready),
        .i_push_data  (w_cx),
        .o_pop_valid  (out_valid),
        .i_pop_ready  (out_ready),
        .o_pop_data   (out_cx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cw_count <= '0;
        end else if (out_valid && out_ready) begin
            r_cw_count <= r_cw_count + CNT_W'(1);
        end
    end

    assign cw_count = r_cw_count;

endmodule

// File: tb/tb_hamming14_4_encoder.sv
// Randomised self-checking bench: a queue-based reference model with a
// table-driven parity definition is compared against the encoder every cycle.
module tb_hamming14_4_encoder;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 16;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [3:0]       in_data   = 4'h0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [13:0]      out_cx;
    logic [CNT_W-1:0] cw_count;
    logic             inj_en    = 1'b0;
    logic [3:0]       inj_pos   = 4'd0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0]      q[$];
    logic [CNT_W-1:0] m_count = '0;
    logic [13:0]      last_cx;

    // Data bits participating in each parity bit p0..p9.
    logic [3:0] pmask [10] = '{4'b0001, 4'b0011, 4'b0101, 4'b0110, 4'b0111,
                               4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101};

    hamming14_4_encoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cx    (out_cx),
        .cw_count  (cw_count)
`ifdef HAMMING_ERR_INJ_EN
        ,
        .inj_en    (inj_en),
        .inj_pos   (inj_pos)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ref_cw(input logic [3:0] d, input logic en,
                                           input logic [3:0] pos);
        logic [13:0] cw;
        cw = {d, 10'b0};
        for (int i = 0; i < 10; i++) cw[i] = ^(d & pmask[i]);
        if (en && pos < 4'd14) cw = cw ^ (14'd1 << pos);
        return cw;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance, update the model.
    task automatic cycle(input logic v, input logic [3:0] d, input logic r);
        logic push;
        logic pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #3;
        check("in_ready", 32'(in_ready), 32'(q.size() < FIFO_DEPTH));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("out_cx", 32'(out_cx), 32'(q[0]));
        check("cw_count", 32'(cw_count), 32'(m_count));
        last_cx = out_cx;
        push = v && (q.size() < FIFO_DEPTH);
        pop  = r && (q.size() != 0);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            m_count++;
        end
        if (push) q.push_back(ref_cw(d, inj_en, inj_pos));
    endtask

    // Handshakes are held active during reset to show they are ignored.
    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'hA;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        q.delete();
        m_count  = '0;
    endtask

`ifdef HAMMING_ERR_INJ_EN
    function automatic logic [3:0] nearest_data(input logic [13:0] cw);
        int best_d    = 0;
        int best_dist = 99;
        for (int c = 0; c < 16; c++) begin
            int dist = $countones(ref_cw(4'(c), 1'b0, 4'd0) ^ cw);
            if (dist < best_dist) begin
                best_dist = dist;
                best_d    = c;
            end
        end
        return 4'(best_d);
    endfunction
`endif

    initial begin
        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_cx", 32'(out_cx), 32'd0);
        check("rst_cw_count", 32'(cw_count), 32'd0);

        // Known vectors
        cycle(1'b1, 4'b0001, 1'b1);
        cycle(1'b0, 4'h0, 1'b1);
        check("cx_0001", 32'(last_cx), 32'h06B7);
        check("count_after_first", 32'(cw_count), 32'd1);
        cycle(1'b1, 4'b1111, 1'b1);
        cycle(1'b1, 4'b0000, 1'b1);
        check("cx_1111", 32'(last_cx), 32'h3E91);
        cycle(1'b0, 4'h0, 1'b1);
        check("cx_0000", 32'(last_cx), 32'h0000);

        // Sweep all nibbles back to back
        for (int d = 0; d < 16; d++) cycle(1'b1, 4'(d), 1'b1);
        cycle(1'b0, 4'h0, 1'b1);

        // Backpressure: third nibble must wait for a slot
        do_reset();
        cycle(1'b1, 4'h1, 1'b0);
        cycle(1'b1, 4'h2, 1'b0);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_head", 32'(out_cx), 32'(ref_cw(4'h1, 1'b0, 4'd0)));
        repeat (3) cycle(1'b1, 4'h3, 1'b0);
        check("bp_head_hold", 32'(out_cx), 32'(ref_cw(4'h1, 1'b0, 4'd0)));
        cycle(1'b1, 4'h3, 1'b1);
        cycle(1'b1, 4'h3, 1'b1);
        repeat (3) cycle(1'b0, 4'h0, 1'b1);
        check("bp_drained_count", 32'(cw_count), 32'd3);

        // Full-rate streaming
        do_reset();
        repeat (1000) cycle(1'b1, 4'($urandom), 1'b1);
        cycle(1'b0, 4'h0, 1'b1);
        check("stream_count", 32'(cw_count), 32'(1000 % (1 << CNT_W)));

        // Random handshakes
        for (int i = 0; i < 2000; i++) begin
`ifdef HAMMING_ERR_INJ_EN
            inj_en  = 1'($urandom_range(0, 1));
            inj_pos = 4'($urandom);
`endif
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
        end
        inj_en = 1'b0;

        // Mid-stream reset discards buffered codewords
        do_reset();
        cycle(1'b1, 4'h5, 1'b0);
        cycle(1'b1, 4'h6, 1'b0);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        do_reset();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_cw_count", 32'(cw_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (4) cycle(1'b0, 4'h0, 1'b1);

`ifdef HAMMING_ERR_INJ_EN
        do_reset();
        inj_en  = 1'b1;
        inj_pos = 4'd10;
        cycle(1'b1, 4'b0001, 1'b1);
        inj_pos = 4'd15;
        cycle(1'b1, 4'b0001, 1'b1);
        check("inj_cx", 32'(last_cx), 32'h02B7);
        check("inj_decode", 32'(nearest_data(last_cx)), 32'd1);
        inj_en = 1'b0;
        cycle(1'b0, 4'h0, 1'b1);
        check("inj_pos15_clean", 32'(last_cx), 32'h06B7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming14_4_encoder.md
Name: hamming14_4_encoder

Overview:
Streaming systematic encoder for the team's (14,4) single-error-correcting code; sits directly upstream of the syndrome decoder stage. Accepts 4-bit data nibbles over a valid/ready handshake and appends 10 parity bits. Buffers finished codewords in a small output FIFO and emits them over a valid/ready handshake to the channel/decoder side. Codeword layout matches the decoder exactly: cx[13:10] = data, cx[9:0] = parity.

Parameters:
FIFO_DEPTH, 2, output buffer depth in codewords; power of two, >= 2
CNT_W, 16, width of the emitted-codeword counter

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on clk rising edge
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data this cycle
in_data  input  4  data nibble d[3:0]
out_valid  output  1  out_cx holds a codeword
out_ready  input  1  downstream accepts out_cx
out_cx  output  14  codeword {d[3:0], p[9:0]}
cw_count  output  CNT_W  count of codewords transferred on the output handshake

Behaviour:
- Parity, with d = in_data: p0=d0; p1=d0^d1; p2=d0^d2; p3=d1^d2; p4=d0^d1^d2; p5=d0^d3; p6=d1^d3; p7=d0^d1^d3; p8=d2^d3; p9=d0^d2^d3.
- Input transfer when in_valid && in_ready. Codeword is computed combinationally and written into the FIFO on that edge.
- in_ready = (occupancy < FIFO_DEPTH). It depends on state only; there is no combinational path from out_ready.
- out_valid = (occupancy != 0). out_cx = FIFO head, driven from a register/array; it is stable while out_valid && !out_ready.
- Output transfer when out_valid && out_ready. The head is popped and cw_count increments by 1, wrapping modulo 2^CNT_W.
- Latency: a nibble accepted at edge N gives out_valid high after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Throughput: 1 codeword/cycle when out_ready is held high.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Full with pop: in_ready is already low, so that cycle does not push, even though a slot frees.
- Empty: no pop, because out_valid is low.
- Pointers: log2(FIFO_DEPTH)-bit read/write pointers wrap naturally. Occupancy is a counter 0..FIFO_DEPTH.
- Reset, including mid-stream: FIFO is flushed.
  - occupancy=0, pointers=0, cw_count=0, out_valid=0, out_cx=0, in_ready=1 from the first cycle after reset.
  - Any in-flight codewords are discarded.
  - Handshakes are ignored during the cycle rst_n is low.
- No state machine beyond the FIFO occupancy (EMPTY / PARTIAL / FULL derived from the counter).

Optional Feature:
Macro HAMMING_ERR_INJ_EN.
- Defined:
  - Adds ports inj_en (input, 1) and inj_pos (input, 4).
  - On an input transfer with inj_en=1 and inj_pos<=13, the stored codeword has bit inj_pos inverted.
  - inj_pos 14/15 means no flip.
  - Used to exercise downstream single-error correction.
- Undefined: the ports are absent and codewords are always clean.

Decomposition:
- Shared package hamming14_4_pkg holds:
  - constants DATA_W=4, PAR_W=10, CW_W=14
  - typedef cw_t (logic [13:0])
  - function calc_parity(d) returning the 10-bit parity
  - The decoder stage reuses the same parity function for syndrome generation.
- One sub-module: hamming_cw_fifo (parameterised sync FIFO with valid/ready, width CW_W, depth FIFO_DEPTH).

Test Plan:
- Reset then in_data=4'b0001, out_ready=1 -> next cycle out_valid=1, out_cx=14'h06B7; cw_count=1 after the transfer.
- in_data=4'b1111 -> out_cx=14'h3E91. in_data=4'b0000 -> out_cx=14'h0000. Sweep all 16 nibbles and check against calc_parity.
- Backpressure: out_ready=0, push 3 nibbles with FIFO_DEPTH=2:
  - in_ready drops after 2 accepts and out_cx holds the first codeword.
  - Raise out_ready: codewords drain in order, in_ready returns, and the third is accepted.
- Streaming with both handshakes every cycle for 1000 cycles -> zero bubbles; cw_count=1000 (CNT_W=8 build: wraps to 232).
- Assert rst_n=0 with 2 codewords buffered -> next cycle out_valid=0, cw_count=0, in_ready=1. The stale codewords never appear.
- HAMMING_ERR_INJ_EN defined, data 4'b0001, inj_en=1, inj_pos=10 -> out_cx=14'h02B7. Feeding this to the decoder yields d=4'b0001.
